instr_prefetch_queue: RTL and testbench
=======================================

Name: instr_prefetch_queue

Overview:
- Fetch front end between the instruction memory port and decode.
- Issues sequential word fetches and buffers returned instructions with their PCs in an in-order FIFO.
- Presents instructions to decode over a valid/ready handshake.
- On a taken branch from execute it redirects the fetch PC, flushes the FIFO and discards responses still in flight.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >= 2)
- MAX_OUTSTANDING, 2, max issued-but-unanswered memory requests (1..7)
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- ex_if_take_branch  in  1  redirect request from execute
- ex_if_branch_target  in  32  redirect address; bits [1:0] ignored, forced 0
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word-aligned fetch address
- imem_rsp_valid  in  1  response valid; in order, no backpressure
- imem_rsp_data  in  32  instruction word
- if_id_valid  out  1  head entry valid for decode
- if_id_ready  in  1  decode consumes head
- if_id_instr_data  out  32  head instruction
- if_id_pc  out  32  head PC
- occupancy  out  $clog2(DEPTH)+1  current FIFO entry count

Behaviour:
- Reset (rst low, async):
  - fetch_pc = RESET_PC; FIFO empty; outstanding = 0; drop_cnt = 0; state FETCH.
  - Outputs: imem_req_valid = 0, if_id_valid = 0, if_id_instr_data = 0, if_id_pc = 0, occupancy = 0.
  - Reset mid-operation discards everything; responses arriving after release with drop_cnt = 0 are accepted. Memory must be reset together with this block.
- Request issue:
  - imem_req_valid = !ex_if_take_branch && (occupancy + outstanding < DEPTH) && (outstanding < MAX_OUTSTANDING).
  - imem_req_addr = fetch_pc.
  - On handshake: fetch_pc += 4 (wraps at 2^32); issued PC is pushed into an internal pending-PC queue (MAX_OUTSTANDING deep); outstanding increments.
- Response (imem_rsp_valid):
  - outstanding decrements; the pending-PC queue pops.
  - If drop_cnt > 0: response discarded, drop_cnt decrements.
  - Otherwise {pending PC, imem_rsp_data} is written to the FIFO tail.
  - No FIFO bypass: minimum latency is request in cycle N, response in N+1, if_id_valid in N+2.
  - Credit rule guarantees the FIFO never overflows. A response with outstanding = 0 is illegal; the bench asserts it never occurs.
- Decode side:
  - if_id_valid = !empty && !ex_if_take_branch; data and PC come from the head.
  - Pop on if_id_valid && if_id_ready.
  - Simultaneous push and pop at full or empty is legal; occupancy stays correct.
- Redirect (ex_if_take_branch high in cycle N):
  - fetch_pc <= {target[31:2], 2'b00}; FIFO cleared; pending-PC queue cleared.
  - No request issues and no pop occurs in cycle N.
  - drop_cnt <= outstanding - (imem_rsp_valid ? 1 : 0). A response arriving in cycle N is itself dropped.
  - New fetch may issue from cycle N+1, even while responses are still being dropped; the credit rule still counts dropped outstanding requests.
  - Back-to-back redirects: each recomputes drop_cnt from the current outstanding; only the last target survives.
- State machine:
  - FETCH: drop_cnt = 0.
  - DISCARD: drop_cnt > 0.
  - FETCH->DISCARD on a redirect with nonzero computed drop_cnt.
  - DISCARD->FETCH when the last dropped response arrives and no redirect is in the same cycle.
  - The state is informational; all behaviour is defined by the counters above.
- Width rules: outstanding and drop_cnt are $clog2(MAX_OUTSTANDING+1) bits; counters never wrap.

Decomposition:
- Shared package (pipeline utilities package):
  - RESET_PC default constant.
  - fetch_entry_t struct {pc[31:0], instr[31:0]}.
  - fetch_state_e enum {FETCH, DISCARD}.
- Sub-module sync_fifo: parameterised DEPTH/WIDTH, with flush, push, pop, count.
  - Instantiated twice: instruction FIFO (64-bit fetch_entry_t) and pending-PC queue (32-bit).

Test Plan:
- Reset release, imem_req_ready = 1, 1-cycle memory returning addr^32'hFFFF_FFFF, if_id_ready = 1: PCs 0,4,8,12 reach decode with matching data; first if_id_valid two cycles after the first request.
- if_id_ready = 0 for 20 cycles: occupancy saturates at 4, no more than 4 requests issued in total, imem_req_valid low; then drain in order without loss.
- Two requests outstanding (PC 0x10, 0x14), redirect to 0x103 same cycle as the 0x10 response: next request address 0x100; 0x10/0x14 never reach decode; first delivered PC 0x100.
- Redirect to 0x40 then 0x80 on consecutive cycles with 2 outstanding: only PCs from 0x80 onward delivered; drop_cnt returns to 0; state back to FETCH.
- imem_req_ready toggling randomly, variable 1-3 cycle response latency, random if_id_ready: delivered PC stream strictly +4 from RESET_PC, never more than MAX_OUTSTANDING outstanding.
- rst asserted with FIFO holding 3 entries and 1 outstanding: all outputs 0 immediately (async); after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_prefetch_queue_pkg.sv
// Shared types and constants for the instruction fetch front end.
package instr_prefetch_queue_pkg;

    localparam int unsigned XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        FETCH   = 1'b0,
        DISCARD = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instr_prefetch_queue_sync_fifo.sv
// Synchronous FIFO with flush; depth need not be a power of two.
module instr_prefetch_queue_sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic [CW-1:0]    count_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (pop_i) rd_ptr_q <= next_ptr(rd_ptr_q);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/instr_prefetch_queue.sv
// Fetch front end: credit-limited sequential fetch, in-order buffering with PCs,
// and branch redirect that flushes the queue and discards in-flight responses.
module instr_prefetch_queue
    import instr_prefetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
    localparam int unsigned CW             = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_if_take_branch,
    input  logic [31:0]   ex_if_branch_target,
    output logic          imem_req_valid,
    input  logic          imem_req_ready,
    output logic [31:0]   imem_req_addr,
    input  logic          imem_rsp_valid,
    input  logic [31:0]   imem_rsp_data,
    output logic          if_id_valid,
    input  logic          if_id_ready,
    output logic [31:0]   if_id_instr_data,
    output logic [31:0]   if_id_pc,
    output logic [CW-1:0] occupancy
);

    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic [OW-1:0] drop_cnt_q, drop_cnt_d;
    fetch_state_e state_q, state_d;

    fetch_entry_t  head_entry;
    fetch_entry_t  push_entry;
    logic [CW-1:0] fifo_cnt;
    logic [31:0]   pend_pc;
    logic [OW-1:0] pend_cnt;
    logic          credit_ok;
    logic          req_fire;
    logic          fifo_pop;
    logic          accept_rsp_c;

    // Buffered entries plus in-flight requests (dropped ones included) may not exceed DEPTH.
    assign credit_ok = ((32'(fifo_cnt) + 32'(outstanding_q)) < DEPTH) &&
                       (32'(outstanding_q) < MAX_OUTSTANDING);

    assign imem_req_valid   = rst && !ex_if_take_branch && credit_ok;
    assign imem_req_addr    = fetch_pc_q;
    assign req_fire         = imem_req_valid && imem_req_ready;

    assign if_id_valid      = (fifo_cnt != '0) && !ex_if_take_branch;
    assign if_id_instr_data = head_entry.instr;
    assign if_id_pc         = head_entry.pc;
    assign occupancy        = fifo_cnt;
    assign fifo_pop         = if_id_valid && if_id_ready;

    assign push_entry = '{pc: pend_pc, instr: imem_rsp_data};

    // Fetch PC, in-flight and drop counters.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
        if (ex_if_take_branch) fetch_pc_d = {ex_if_branch_target[31:2], 2'b00};
        case ({req_fire, imem_rsp_valid})
            2'b10:   outstanding_d = outstanding_q + OW'(1);
            2'b01:   outstanding_d = outstanding_q - OW'(1);
            default: outstanding_d = outstanding_q;
        endcase
        if (ex_if_take_branch) begin
            drop_cnt_d = outstanding_q - OW'(imem_rsp_valid);
        end else if (imem_rsp_valid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - OW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            state_q       <= FETCH;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            state_q       <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (drop_cnt_d != '0) state_d = DISCARD;
            DISCARD: if (drop_cnt_d == '0) state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // A response is kept only when nothing is left to drop and no redirect is in progress.
    always_comb begin
        accept_rsp_c = 1'b0;
        if (imem_rsp_valid && !ex_if_take_branch && (drop_cnt_q == '0)) accept_rsp_c = 1'b1;
    end

    instr_prefetch_queue_sync_fifo #(
        .DEPTH(DEPTH),
        .WIDTH($bits(fetch_entry_t))
    ) u_instr_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (ex_if_take_branch),
        .push_i     (accept_rsp_c),
        .push_data_i(push_entry),
        .pop_i      (fifo_pop),
        .pop_data_o (head_entry),
        .count_o    (fifo_cnt)
    );

    // Holds PCs of live (non-dropped) requests only, so dropped responses never pop it.
    instr_prefetch_queue_sync_fifo #(
        .DEPTH(MAX_OUTSTANDING),
        .WIDTH(XLEN)
    ) u_pend_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (ex_if_take_branch),
        .push_i     (req_fire),
        .push_data_i(fetch_pc_q),
        .pop_i      (accept_rsp_c && (pend_cnt != '0)),
        .pop_data_o (pend_pc),
        .count_o    (pend_cnt)
    );

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue with a variable-latency in-order memory model.
module tb_instr_prefetch_queue;

    localparam int MAX_OUT = 2;

    logic        clk;
    logic        rst;
    logic        br;
    logic [31:0] tgt;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_data;
    logic [31:0] id_pc;
    logic [2:0]  occ;

    instr_prefetch_queue dut (
        .clk                (clk),
        .rst                (rst),
        .ex_if_take_branch  (br),
        .ex_if_branch_target(tgt),
        .imem_req_valid     (req_valid),
        .imem_req_ready     (req_ready),
        .imem_req_addr      (req_addr),
        .imem_rsp_valid     (rsp_valid),
        .imem_rsp_data      (rsp_data),
        .if_id_valid        (id_valid),
        .if_id_ready        (id_ready),
        .if_id_instr_data   (id_data),
        .if_id_pc           (id_pc),
        .occupancy          (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int req_cnt = 0;
    int viol = 0;
    int lat_min = 1;
    int lat_max = 1;
    logic [31:0] got[$];

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];

    typedef struct {
        logic        idr;
        logic        rv;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] pc;
        logic [2:0]  occ;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] got_at(input int k);
        return (k < got.size()) ? got[k] : 32'hDEAD_BEEF;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        got.delete();
        req_cnt = 0;
        viol    = 0;
        rst     = 1'b1;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_got(input int n, input int budget);
        int t;
        t = 0;
        while (got.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("delivery_count_reached", 32'(got.size() >= n), 32'd1);
    endtask

    // In-order memory: one response per cycle at most, latency lat_min..lat_max.
    initial begin : mem_model
        int cyc;
        int last_due;
        int d;
        cyc       = 0;
        last_due  = 0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mq.delete();
                last_due = 0;
            end else if (req_valid && req_ready) begin
                d = cyc + int'($urandom_range(lat_max, lat_min));
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                mq.push_back('{addr: req_addr, due: d});
            end
            @(posedge clk);
            #1;
            cyc++;
            if (rst && mq.size() > 0 && mq[0].due <= cyc) begin
                rsp_valid = 1'b1;
                rsp_data  = mq[0].addr ^ 32'hFFFF_FFFF;
                void'(mq.pop_front());
            end else begin
                rsp_valid = 1'b0;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst) begin
                if (req_valid && req_ready) req_cnt++;
                if (id_valid && id_ready) begin
                    got.push_back(id_pc);
                    check("instr_matches_pc", id_data, id_pc ^ 32'hFFFF_FFFF);
                end
                if (rsp_valid) check("rsp_only_when_outstanding", 32'(dut.outstanding_q != 0), 32'd1);
                if (int'(dut.outstanding_q) > MAX_OUT) viol++;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d expected finish", $time);
        $fatal(1);
    end

    initial begin : main
        vec_t vecs[11];
        int   errs;

        br        = 1'b0;
        tgt       = '0;
        req_ready = 1'b1;
        id_ready  = 1'b1;
        rst       = 1'b0;

        // Reset state
        #2;
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_id_data", id_data, 32'd0);
        check("rst_id_pc", id_pc, 32'd0);
        check("rst_occupancy", 32'(occ), 32'd0);

        // Startup trace, 1-cycle memory, decode stalls in the middle
        vecs[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 3'd0};
        vecs[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00, 3'd0};
        vecs[2]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00, 3'd1};
        vecs[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h04, 3'd1};
        vecs[4]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h04, 3'd2};
        vecs[5]  = '{1'b0, 1'b0, 32'h14, 1'b1, 32'h04, 3'd3};
        vecs[6]  = '{1'b0, 1'b0, 32'h14, 1'b1, 32'h04, 3'd4};
        vecs[7]  = '{1'b1, 1'b0, 32'h14, 1'b1, 32'h04, 3'd4};
        vecs[8]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h08, 3'd3};
        vecs[9]  = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h0C, 3'd2};
        vecs[10] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10, 3'd2};
        lat_min = 1;
        lat_max = 1;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            id_ready = vecs[i].idr;
            @(negedge clk);
            check($sformatf("vec%0d_req_valid", i), 32'(req_valid), 32'(vecs[i].rv));
            check($sformatf("vec%0d_req_addr", i), req_addr, vecs[i].addr);
            check($sformatf("vec%0d_id_valid", i), 32'(id_valid), 32'(vecs[i].iv));
            check($sformatf("vec%0d_id_pc", i), id_pc, vecs[i].pc);
            check($sformatf("vec%0d_occupancy", i), 32'(occ), 32'(vecs[i].occ));
            @(posedge clk);
            #1;
        end

        // Saturation with decode stalled, then drain in order
        id_ready = 1'b0;
        do_reset();
        cycles(20);
        @(negedge clk);
        check("sat_occupancy", 32'(occ), 32'd4);
        check("sat_req_count", 32'(req_cnt), 32'd4);
        check("sat_req_valid", 32'(req_valid), 32'd0);
        @(posedge clk);
        #1;
        id_ready = 1'b1;
        wait_got(8, 60);
        for (int k = 0; k < 8; k++) check($sformatf("drain_pc%0d", k), got_at(k), 32'(4 * k));

        // Redirect coinciding with the first of two responses
        lat_min   = 2;
        lat_max   = 2;
        br        = 1'b1;
        tgt       = 32'h10;
        id_ready  = 1'b1;
        do_reset();
        cycles(1);
        br = 1'b0;
        cycles(2);
        br  = 1'b1;
        tgt = 32'h103;
        @(negedge clk);
        check("redir_req_valid_blocked", 32'(req_valid), 32'd0);
        check("redir_id_valid_blocked", 32'(id_valid), 32'd0);
        @(posedge clk);
        #1;
        br = 1'b0;
        @(negedge clk);
        check("redir_drop_cnt", 32'(dut.drop_cnt_q), 32'd1);
        check("redir_state_discard", 32'(dut.state_q), 32'd1);
        check("redir_occupancy", 32'(occ), 32'd0);
        check("redir_req_valid", 32'(req_valid), 32'd1);
        check("redir_req_addr", req_addr, 32'h100);
        wait_got(2, 40);
        check("redir_first_pc", got_at(0), 32'h100);
        check("redir_second_pc", got_at(1), 32'h104);

        // Back-to-back redirects with two in flight
        lat_min = 3;
        lat_max = 3;
        br      = 1'b0;
        do_reset();
        cycles(2);
        br  = 1'b1;
        tgt = 32'h40;
        cycles(1);
        tgt = 32'h80;
        @(negedge clk);
        check("b2b_req_valid_blocked", 32'(req_valid), 32'd0);
        @(posedge clk);
        #1;
        br = 1'b0;
        @(negedge clk);
        check("b2b_drop_cnt", 32'(dut.drop_cnt_q), 32'd1);
        check("b2b_state_discard", 32'(dut.state_q), 32'd1);
        check("b2b_req_valid", 32'(req_valid), 32'd1);
        check("b2b_req_addr", req_addr, 32'h80);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("b2b_drop_cnt_clear", 32'(dut.drop_cnt_q), 32'd0);
        check("b2b_state_fetch", 32'(dut.state_q), 32'd0);
        wait_got(2, 40);
        check("b2b_first_pc", got_at(0), 32'h80);
        check("b2b_second_pc", got_at(1), 32'h84);

        // Random ready/latency, stream must be contiguous from reset PC
        lat_min = 1;
        lat_max = 3;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            req_ready = 1'($urandom_range(1, 0));
            id_ready  = 1'($urandom_range(1, 0));
            @(posedge clk);
            #1;
        end
        errs = 0;
        for (int k = 0; k < got.size(); k++) if (got[k] !== 32'(4 * k)) errs++;
        check("rand_stream_errors", 32'(errs), 32'd0);
        check("rand_enough_delivered", 32'(got.size() > 50), 32'd1);
        check("rand_outstanding_bound", 32'(viol), 32'd0);

        // Asynchronous reset with a partly filled queue
        lat_min   = 1;
        lat_max   = 1;
        req_ready = 1'b1;
        id_ready  = 1'b0;
        do_reset();
        cycles(4);
        @(negedge clk);
        check("pre_rst_occupancy", 32'(occ), 32'd3);
        check("pre_rst_outstanding", 32'(dut.outstanding_q), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_req_valid", 32'(req_valid), 32'd0);
        check("async_rst_id_valid", 32'(id_valid), 32'd0);
        check("async_rst_id_data", id_data, 32'd0);
        check("async_rst_id_pc", id_pc, 32'd0);
        check("async_rst_occupancy", 32'(occ), 32'd0);
        cycles(2);
        got.delete();
        id_ready = 1'b1;
        rst      = 1'b1;
        @(negedge clk);
        check("post_rst_req_valid", 32'(req_valid), 32'd1);
        check("post_rst_req_addr", req_addr, 32'h0);
        wait_got(1, 20);
        check("post_rst_first_pc", got_at(0), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
